// File: rtl/auth_status_tx.sv
// auth_status_tx: reports scooter power/authentication status to the BLE
// module as 4-byte frames (A5, code, flags, checksum) over an 8N1 UART line.
// Power-up sends 'G', power-down sends 'S'. Define AUTH_TX_HEARTBEAT_EN to
// add a periodic 'H' heartbeat frame while powered.
`timescale 1ns/1ps
module auth_status_tx #(
  parameter int BAUD_DIV  = 2604,
  parameter int HB_PERIOD = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_up,
  input  logic       rider_off,
  input  logic [7:0] batt,
  output logic       TX,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t      state_r;
  logic        pwr_up_ff;
  logic        pend_g;
  logic        pend_s;
  logic        pend_h;
  logic        hb_tick_s;
  logic        rise_s;
  logic        fall_s;
  logic        start_s;
  logic [7:0]  code_s;
  logic [7:0]  byte_s;
  logic [7:0]  code_r;
  logic [7:0]  flags_r;
  logic [7:0]  shift_r;
  logic [1:0]  idx_r;
  logic [2:0]  bit_r;
  logic [BW-1:0] baud_r;
  logic        tx_r;
  logic        busy_r;
  logic        done_r;

  assign rise_s  = pwr_up & ~pwr_up_ff;
  assign fall_s  = ~pwr_up & pwr_up_ff;
  assign start_s = (state_r == IDLE) && (pend_s || pend_g || pend_h);

  assign TX         = tx_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

`ifdef AUTH_TX_HEARTBEAT_EN
  localparam int HW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam logic [HW-1:0] HB_LAST = HW'(HB_PERIOD - 1);
  logic [HW-1:0] hb_cnt_r;

  assign hb_tick_s = pwr_up_ff && (hb_cnt_r == HB_LAST);

  // Heartbeat counter: free-runs while powered, independent of frame activity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_r <= {HW{1'b0}};
    end else if (!pwr_up_ff || hb_tick_s) begin
      hb_cnt_r <= {HW{1'b0}};
    end else begin
      hb_cnt_r <= hb_cnt_r + {{(HW-1){1'b0}}, 1'b1};
    end
  end

  // Heartbeat request: a power-down drops any heartbeat still waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_h <= 1'b0;
    end else if (fall_s) begin
      pend_h <= 1'b0;
    end else if (hb_tick_s) begin
      pend_h <= 1'b1;
    end else if (start_s && !pend_s && !pend_g) begin
      pend_h <= 1'b0;
    end else begin
      pend_h <= pend_h;
    end
  end
`else
  assign hb_tick_s = 1'b0;
  assign pend_h    = 1'b0;
`endif

  // Edge detector and sticky G/S requests; the latest power state wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_up_ff <= 1'b0;
      pend_g    <= 1'b0;
      pend_s    <= 1'b0;
    end else begin
      pwr_up_ff <= pwr_up;
      if (fall_s) begin
        pend_s <= 1'b1;
      end else if (rise_s || (start_s && pend_s)) begin
        pend_s <= 1'b0;
      end else begin
        pend_s <= pend_s;
      end
      if (rise_s) begin
        pend_g <= 1'b1;
      end else if (fall_s || (start_s && !pend_s)) begin
        pend_g <= 1'b0;
      end else begin
        pend_g <= pend_g;
      end
    end
  end

  // Frame code arbitration: S beats G beats H
  always_comb begin
    code_s = 8'h48;
    if (pend_s) begin
      code_s = 8'h53;
    end else if (pend_g) begin
      code_s = 8'h47;
    end else begin
      code_s = 8'h48;
    end
  end

  // Byte selection for the current frame position
  always_comb begin
    byte_s = 8'hA5;
    case (idx_r)
      2'd0:    byte_s = 8'hA5;
      2'd1:    byte_s = code_r;
      2'd2:    byte_s = flags_r;
      2'd3:    byte_s = code_r ^ flags_r;
      default: byte_s = 8'hA5;
    endcase
  end

  // Frame sequencer and 8N1 serializer with registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      code_r  <= 8'h00;
      flags_r <= 8'h00;
      shift_r <= 8'h00;
      idx_r   <= 2'd0;
      bit_r   <= 3'd0;
      baud_r  <= {BW{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          idx_r  <= 2'd0;
          if (start_s) begin
            // Snapshot status so bytes in flight never change mid-frame
            code_r  <= code_s;
            flags_r <= (batt & 8'hFE) | {7'd0, rider_off};
            state_r <= LOAD;
          end
        end
        LOAD: begin
          shift_r <= byte_s;
          tx_r    <= 1'b0;
          busy_r  <= 1'b1;
          baud_r  <= BAUD_LAST;
          state_r <= START;
        end
        START: begin
          if (baud_r == {BW{1'b0}}) begin
            tx_r    <= shift_r[0];
            shift_r <= {1'b0, shift_r[7:1]};
            bit_r   <= 3'd0;
            baud_r  <= BAUD_LAST;
            state_r <= DATA;
          end else begin
            baud_r <= baud_r - {{(BW-1){1'b0}}, 1'b1};
          end
        end
        DATA: begin
          if (baud_r == {BW{1'b0}}) begin
            baud_r <= BAUD_LAST;
            if (bit_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              tx_r    <= shift_r[0];
              shift_r <= {1'b0, shift_r[7:1]};
              bit_r   <= bit_r + 3'd1;
            end
          end else begin
            baud_r <= baud_r - {{(BW-1){1'b0}}, 1'b1};
          end
        end
        STOP: begin
          if (baud_r == {BW{1'b0}}) begin
            if (idx_r == 2'd3) begin
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              idx_r   <= idx_r + 2'd1;
              state_r <= LOAD;
            end
          end else begin
            baud_r <= baud_r - {{(BW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auth_status_tx.sv
// Self-checking bench for auth_status_tx: a UART decoder turns TX back into
// bytes, and expected frames are built from the status-frame rules.
`timescale 1ns/1ps
module tb_auth_status_tx;

  localparam int BD = 16;
  localparam int HB = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwr_up;
  logic       rider_off;
  logic [7:0] batt;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int         n_checks = 0;
  int         n_err = 0;
  int         epoch = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  auth_status_tx #(.BAUD_DIV(BD), .HB_PERIOD(HB)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .rider_off(rider_off),
    .batt(batt), .TX(tx), .busy(busy), .frame_done(frame_done)
  );

  // Line decoder: mid-bit sampling, bytes cut by a reset are discarded
  initial begin : uart_mon
    logic [7:0] b;
    logic       ok;
    int         ep;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ep = epoch;
        ok = 1'b1;
        b  = 8'h00;
        repeat (BD/2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx;
        end
        repeat (BD) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        if (ok && ep == epoch && rst_n === 1'b1) rx_q.push_back(b);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int cnt = 0;
    while (rx_q.size() < n && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, ".timeout"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  // Reference frame: header, code, flags byte (batt bit0 = rider_off), xor sum
  task automatic expect_frame(input string tag, input logic [7:0] code,
                              input logic [7:0] b, input logic r);
    logic [7:0] exp[4];
    logic [7:0] got;
    logic [7:0] flags;
    flags = {b[7:1], r};
    exp   = '{8'hA5, code, flags, code ^ flags};
    for (int i = 0; i < 4; i++) begin
      if (rx_q.size() > 0) got = rx_q.pop_front();
      else got = 8'hxx;
      chk($sformatf("%s.byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
  endtask

  initial begin : main
    int         lat;
    int         dur;
    logic [7:0] rb;
    logic       rr;

    rst_n = 1'b0; pwr_up = 1'b0; rider_off = 1'b0; batt = 8'h00;
    tick(3);
    chk("reset.tx", {31'd0, tx}, 32'd1);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    tick(5);
    chk("idle.tx", {31'd0, tx}, 32'd1);

    // Power-up frame: latency, length, done/busy alignment, batt snapshot
    batt = 8'h64; rider_off = 1'b0; pwr_up = 1'b1;
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("g.latency", 32'(lat), 32'd3);
    chk("g.busy_rise", {31'd0, busy}, 32'd1);
    batt = 8'h9B;
    dur = 0;
    while (frame_done !== 1'b1 && dur < 2000) begin
      @(negedge clk);
      dur++;
    end
    chk("g.frame_len", 32'(dur), 32'd643);
    chk("g.busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("g.done_pulse", {31'd0, frame_done}, 32'd0);
    chk("g.busy_fall", {31'd0, busy}, 32'd0);
    wait_bytes("g", 4, 100);
    expect_frame("g", 8'h47, 8'h64, 1'b0);

    // Power-down frame
    batt = 8'h3F; rider_off = 1'b1; pwr_up = 1'b0;
    wait_bytes("s", 4, 900);
    expect_frame("s", 8'h53, 8'h3F, 1'b1);
    tick(20);

    // Rise then quick fall while idle: G then S
    rb = 8'($urandom); rr = 1'($urandom);
    batt = rb; rider_off = rr;
    pwr_up = 1'b1; tick(5); pwr_up = 1'b0;
    wait_bytes("gs", 8, 1600);
    expect_frame("gs.g", 8'h47, rb, rr);
    expect_frame("gs.s", 8'h53, rb, rr);
    tick(20);

    // Toggles during a G frame collapse into the final state's frame
    rb = 8'($urandom); rr = 1'($urandom);
    batt = rb; rider_off = rr;
    pwr_up = 1'b1; tick(60);
    pwr_up = 1'b0; tick(20);
    pwr_up = 1'b1; tick(20);
    pwr_up = 1'b0;
    wait_bytes("tog", 8, 1600);
    expect_frame("tog.g", 8'h47, rb, rr);
    expect_frame("tog.s", 8'h53, rb, rr);
    tick(800);
    chk("tog.no_extra", 32'(rx_q.size()), 32'd0);

    // Held power: heartbeats every HB cycles when enabled
    rb = 8'($urandom); rr = 1'($urandom);
    batt = rb; rider_off = rr;
    pwr_up = 1'b1; tick(4500); pwr_up = 1'b0;
`ifdef AUTH_TX_HEARTBEAT_EN
    wait_bytes("hb", 16, 2000);
    expect_frame("hb.g", 8'h47, rb, rr);
    expect_frame("hb.h1", 8'h48, rb, rr);
    expect_frame("hb.h2", 8'h48, rb, rr);
    expect_frame("hb.s", 8'h53, rb, rr);
`else
    wait_bytes("hb", 8, 1000);
    expect_frame("hb.g", 8'h47, rb, rr);
    expect_frame("hb.s", 8'h53, rb, rr);
`endif
    tick(800);
    chk("hb.no_extra", 32'(rx_q.size()), 32'd0);

    // Reset during byte 2 start bit, then a fresh G frame on release
    rb = 8'($urandom); rr = 1'($urandom);
    batt = rb; rider_off = rr;
    pwr_up = 1'b1;
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rst.frame_start", 32'(lat), 32'd3);
    tick(10*BD + 1 + BD/2);
    chk("rst.in_start_bit", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    epoch++;
    #1;
    chk("rst.tx_async", {31'd0, tx}, 32'd1);
    chk("rst.busy_async", {31'd0, busy}, 32'd0);
    tick(200);
    rx_q.delete();
    rb = 8'($urandom); rr = 1'($urandom);
    batt = rb; rider_off = rr;
    rst_n = 1'b1;
    wait_bytes("rst.g", 4, 900);
    expect_frame("rst.g", 8'h47, rb, rr);
    tick(20);
    pwr_up = 1'b0;
    wait_bytes("rst.s", 4, 900);
    expect_frame("rst.s", 8'h53, rb, rr);
    tick(50);
    chk("rst.no_extra", 32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/auth_status_tx.md
# auth_status_tx

- Transmit-side companion to the authentication receiver: reports scooter power/authentication status to the BLE121LR module over a dedicated UART TX line.
- Watches `pwr_up` for edges and sends a 4-byte status frame for each: `G` on power-up, `S` on power-down, and `H` as a periodic heartbeat while powered.
- Contains its own 8N1 serializer, so it needs nothing beyond the status inputs and the TX pin.

## Interface
Parameters:
- BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200 baud); legal ≥ 4.
- HB_PERIOD, 50_000_000, clk cycles between heartbeat requests while powered.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: asynchronous, active-low.
- pwr_up  input  1  power-enable from the authentication block; synchronous to clk.
- rider_off  input  1  rider-absent flag; bit 0 of the flags byte.
- batt  input  8  battery level, sampled at frame start.
- TX  output  1  UART serial out, idle high.
- busy  output  1  high while a frame is in flight.
- frame_done  output  1  one-cycle pulse at the end of each frame.

## Operation
- Frame format, 4 bytes in order:
  - 0xA5 header.
  - Code: `G`=0x47, `S`=0x53, `H`=0x48.
  - {batt_s[7:1], rider_off_s}: the sampled batt with bit 0 replaced by the sampled rider_off.
  - Checksum = code ^ byte3.
- Event detection:
  - `pwr_up_ff` registers pwr_up.
  - Rise (pwr_up & ~pwr_up_ff) sets pend_g; fall sets pend_s.
  - Heartbeat terminal count sets pend_h.
  - Pending flags are sticky until their frame starts; a repeated event while pending collapses into one frame.
- Cancellation: a rise clears pend_s and a fall clears pend_g, so the latest power state wins. pend_h clears on any fall.
- Arbitration in IDLE: S > G > H. The chosen flag clears on the frame-start cycle.
- batt and rider_off are captured into 8-bit holding registers on the frame-start cycle and stay stable for the whole frame.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE → LOAD when any flag is pending.
  - LOAD selects the byte at the current index (0..3) into the shift register.
  - START drives TX=0 for BAUD_DIV cycles.
  - DATA shifts 8 bits LSB-first, BAUD_DIV cycles each.
  - STOP drives TX=1 for BAUD_DIV cycles; index < 3 → LOAD, else → IDLE with frame_done asserted.
- Baud counter: down-counter of width $clog2(BAUD_DIV), reloaded on entering START/DATA-bit/STOP. The bit counter is 3 bits.
- Heartbeat counter, width $clog2(HB_PERIOD):
  - Counts only while pwr_up_ff=1; held at 0 otherwise.
  - At HB_PERIOD-1 it wraps to 0 and sets pend_h.
  - It is not reset by frame activity.

## Timing
- Reset values: TX=1, busy=0, frame_done=0; all pend flags, pwr_up_ff, counters and shift register 0; state IDLE.
- Power-up after reset: because pwr_up_ff resets to 0, pwr_up held high across reset release produces one G frame.
- Start latency from edge E (first clk edge sampling a new pwr_up level while idle):
  - Flag set at E.
  - LOAD at E+1.
  - TX falls and busy rises at E+2.
- Byte timing: every byte is exactly 10·BAUD_DIV cycles. LOAD costs 1 extra cycle, with TX held high.
- Frame length: from TX fall to frame_done is 40·BAUD_DIV+3 cycles.
- frame_done is coincident with the last cycle busy=1.
- After frame_done the FSM spends at least one cycle in IDLE before the next LOAD.
- Events during a frame only latch; they never alter bytes in flight.
- Reset mid-frame: TX returns to 1 asynchronously, and no partial-frame resume occurs.

## Configuration
- AUTH_TX_HEARTBEAT_EN defined: heartbeat counter and pend_h are compiled in; H frames are sent every HB_PERIOD cycles while powered.
- Not defined: counter and pend_h are absent, only G/S frames are sent, and HB_PERIOD is ignored.

## Test plan
Bench uses BAUD_DIV=16 and HB_PERIOD=2000.
- Reset, then pwr_up 0→1 with batt=0x64, rider_off=0 → bytes A5,47,64,23 decoded from TX; frame_done after 643 cycles from TX fall.
- While powered, pwr_up 1→0 with batt=0x3F, rider_off=1 → bytes A5,53,3F,6C.
- pwr_up rise immediately followed by fall 5 cycles later while idle → single G frame then single S frame. Toggling during the G frame leaves only the final state's frame queued.
- pwr_up held 1 for 4500 cycles with the macro defined → one G frame plus two H frames (A5,48,b,48^b). Without the macro → G frame only.
- Assert rst_n=0 mid-byte 2 → TX=1 and busy=0 immediately; after release with pwr_up=1 → a fresh complete G frame.
- batt changed mid-frame → transmitted byte3/checksum reflect the value at frame start.
